// File: rtl/del_locate.sv
// Single-deletion locator: walks a received DNA word against its one-digit-longer
// reference from the MSB down and reports where a digit was lost and its value.
module del_locate #(
    parameter int N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   word_in,
    input  logic [2*N+1:0]   ref_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   word_pass,
    output logic [6:0]       missing_index,
    output logic [1:0]       missing_digit,
    output logic             err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // out_valid and the result fields stay constant until that transfer occurs.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] VERIFY = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]     state;
    logic [2*N+1:0] ref_q;
    logic [6:0]     pos;
    logic [6:0]     pos_m1;
    logic [1:0]     ref_dig;
    logic [1:0]     rcv_hi;
    logic [1:0]     rcv_lo;

    // Shift-based digit pick keeps out-of-range positions harmless (they read as 0).
    assign pos_m1  = pos - 7'd1;
    assign ref_dig = 2'(ref_q >> {pos, 1'b0});
    assign rcv_hi  = 2'(word_pass >> {pos_m1, 1'b0});
    assign rcv_lo  = 2'(word_pass >> {pos, 1'b0});

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ref_q         <= '0;
            pos           <= '0;
            word_pass     <= '0;
            missing_index <= '0;
            missing_digit <= '0;
            err           <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_pass <= word_in;
                        ref_q     <= ref_word;
                        pos       <= 7'(N);
                        err       <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (pos == 7'd0) begin
                        // No mismatch anywhere above: the LSB digit was the one lost.
                        missing_index <= 7'(N - 1);
                        missing_digit <= ref_dig;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else if (ref_dig != rcv_hi) begin
                        missing_index <= 7'(N - 1) - pos;
                        missing_digit <= ref_dig;
                        pos           <= pos_m1;
                        state         <= VERIFY;
                    end else begin
                        pos <= pos_m1;
                    end
                end
                VERIFY: begin
                    if (ref_dig != rcv_lo) begin
                        err <= 1'b1;
                    end
                    if (pos == 7'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        pos <= pos_m1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_del_locate.sv
// Bench for del_locate (N=6): directed table, handshake/reset corner sequences and
// random transactions checked against a deletion-search reference model.
module tb_del_locate;

    localparam int N  = 6;
    localparam int RW = 2*N + 2;
    localparam int WW = 2*N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] word_in = '0;
    logic [RW-1:0] ref_word = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] word_pass;
    logic [6:0]    missing_index;
    logic [1:0]    missing_digit;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;

    // expected result packed as {index, digit, err, word}
    localparam int EW = 7 + 2 + 1 + WW;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [RW-1:0] ref_w;
        logic [WW-1:0] rcv_w;
        logic [6:0]    idx;
        logic [1:0]    dig;
        logic          e;
    } vec_t;

    vec_t vecs[4];

    del_locate #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .word_in(word_in), .ref_word(ref_word), .out_valid(out_valid),
        .out_ready(out_ready), .word_pass(word_pass), .missing_index(missing_index),
        .missing_digit(missing_digit), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dg(input logic [31:0] w, input int i);
        return int'((w >> (2*i)) & 32'd3);
    endfunction

    function automatic logic [WW-1:0] delete_at(input logic [RW-1:0] r, input int k);
        logic [WW-1:0] o;
        o = '0;
        for (int j = 0; j < N; j++)
            o[2*j +: 2] = 2'(dg(32'(r), (j < k) ? j : j + 1));
        return o;
    endfunction

    // Index comes from the first MSB-side mismatch; err means no single deletion explains rcv.
    function automatic logic [EW-1:0] model(input logic [RW-1:0] r, input logic [WW-1:0] c);
        int  p;
        bit  found;
        bit  e;
        p = 0;
        found = 0;
        for (int k = N; k >= 1; k--)
            if (!found && dg(32'(r), k) != dg(32'(c), k - 1)) begin
                p = k;
                found = 1;
            end
        e = 1;
        for (int k = 0; k <= N; k++)
            if (delete_at(r, k) == c) e = 0;
        return {7'((N - 1 - p) & 127), 2'(dg(32'(r), p)), e, c};
    endfunction

    // Downstream ins_digit behaviour: put the digit back at p = (N - index - 1) mod 128.
    function automatic logic [RW-1:0] reinsert(input logic [WW-1:0] c, input logic [6:0] idx,
                                               input logic [1:0] d);
        logic [RW-1:0] o;
        int p;
        p = (N - int'(idx) - 1) & 127;
        o = '0;
        for (int j = 0; j <= N; j++) begin
            if (j < p)       o[2*j +: 2] = 2'(dg(32'(c), j));
            else if (j == p) o[2*j +: 2] = d;
            else             o[2*j +: 2] = 2'(dg(32'(c), j - 1));
        end
        return o;
    endfunction

    task automatic drive_input(input logic [RW-1:0] r, input logic [WW-1:0] c);
        @(negedge clk);
        ref_word = r;
        word_in  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ref_word = RW'($urandom);
        word_in  = WW'($urandom);
    endtask

    task automatic run_txn(input logic [RW-1:0] r, input logic [WW-1:0] c, input int hold,
                           input string tag);
        int cycles;
        logic [EW-1:0] exp;
        logic [6:0] s_idx;
        logic [1:0] s_dig;
        logic s_err;
        logic [WW-1:0] s_word;
        exp_q.push_back(model(r, c));
        drive_input(r, c);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: out_valid not seen within 20 cycles", tag);
            void'(exp_q.pop_front());
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
        end
        check({tag, " latency"}, 32'(cycles), 32'(N + 1));
        @(negedge clk);
        exp = exp_q.pop_front();
        check({tag, " index"}, 32'(missing_index), 32'(exp[EW-1 -: 7]));
        check({tag, " digit"}, 32'(missing_digit), 32'(exp[WW+2 -: 2]));
        check({tag, " err"}, 32'(err), 32'(exp[WW]));
        check({tag, " word_pass"}, 32'(word_pass), 32'(exp[WW-1:0]));
        if (!exp[WW])
            check({tag, " rebuilt"}, 32'(reinsert(word_pass, missing_index, missing_digit)),
                  32'(r));
        s_idx = missing_index; s_dig = missing_digit; s_err = err; s_word = word_pass;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            word_in  = WW'($urandom);
            ref_word = RW'($urandom);
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold stable"}, 32'({missing_index, missing_digit, err, word_pass}),
                  32'({s_idx, s_dig, s_err, s_word}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, " in_ready before handshake"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " out_valid after"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
        check({tag, " err after"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [RW-1:0] r;
        logic [WW-1:0] c;
        vecs[0] = '{ref_w: 14'h06C6, rcv_w: 12'h1C6, idx: 7'd1,   dig: 2'd2, e: 1'b0};
        vecs[1] = '{ref_w: 14'h06C6, rcv_w: 12'h6C6, idx: 7'h7F,  dig: 2'd0, e: 1'b0};
        vecs[2] = '{ref_w: 14'h06C6, rcv_w: 12'h1B1, idx: 7'd5,   dig: 2'd2, e: 1'b0};
        vecs[3] = '{ref_w: 14'h06C6, rcv_w: 12'h1C4, idx: 7'd1,   dig: 2'd2, e: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", 32'({missing_index, missing_digit, err, word_pass}), 32'd0);

        // Directed table: constants against the DUT, then the full transaction flow.
        for (int i = 0; i < 4; i++) begin
            drive_input(vecs[i].ref_w, vecs[i].rcv_w);
            repeat (N + 1) @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d index", i), 32'(missing_index), 32'(vecs[i].idx));
            check($sformatf("tbl%0d digit", i), 32'(missing_digit), 32'(vecs[i].dig));
            check($sformatf("tbl%0d err", i), 32'(err), 32'(vecs[i].e));
            check($sformatf("tbl%0d word_pass", i), 32'(word_pass), 32'(vecs[i].rcv_w));
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        // Stall for 5 cycles, then back-to-back LSB-lost case.
        run_txn(14'h06C6, 12'h1C6, 5, "stall");
        run_txn(14'h06C6, 12'h1B1, 0, "b2b");

        // Reset three cycles into a scan drops the transaction.
        drive_input(14'h06C6, 12'h1C6);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst outputs", 32'({missing_index, missing_digit, err, word_pass}), 32'd0);
        repeat (N + 2) @(negedge clk);
        check("midrst no output", 32'(out_valid), 32'd0);
        run_txn(14'h06C6, 12'h6C6, 0, "post_rst");

        for (int t = 0; t < 40; t++) begin
            r = RW'($urandom);
            c = delete_at(r, int'($urandom_range(0, N)));
            if ($urandom_range(0, 3) == 0)
                c = c ^ (WW'($urandom_range(1, 3)) << (2 * $urandom_range(0, N - 1)));
            run_txn(r, c, int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
